// File: rtl/keypad_entry.sv
// keypad_entry: one event per key press from the matrix scanner, decimal entry FSM, valid/ready commit
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   key_code, key_press   scanner code and press level (code valid while key_press is 1)
//   out_ready             consumer accepts the committed value
//   out_valid, out_value  committed value handshake
//   acc_value             live accumulator for display
//   entering              high while an entry is in progress
//   overflow              sticky flag: a digit was rejected for range in this entry
module keypad_entry #(
    parameter int WIDTH          = 16,
    parameter int RELEASE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       key_code,
    input  logic             key_press,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [WIDTH-1:0] acc_value,
    output logic             entering,
    output logic             overflow
);
    localparam int CW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [CW-1:0] REL_MAX = CW'(RELEASE_CYCLES);

    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    state_t           state, state_nxt;
    logic             armed;
    logic [CW-1:0]    rel_cnt;
    logic [WIDTH-1:0] acc, acc_nxt, out_nxt;
    logic             ov, ov_nxt, valid_nxt;
    logic             ev;
    logic [WIDTH+3:0] mac;

    assign ev  = key_press && armed;
    // Full-width multiply-add so the range check sees the true result, never a wrapped one
    assign mac = {4'b0, acc} * (WIDTH+4)'(10) + (WIDTH+4)'(key_code);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ov_nxt    = ov;
        valid_nxt = out_valid;
        out_nxt   = out_value;
        case (state)
            IDLE: if (ev && key_code == 4'hE) begin
                state_nxt = ENTRY;
                acc_nxt   = '0;
                ov_nxt    = 1'b0;
            end
            ENTRY: if (ev) begin
                if (key_code <= 4'h9) begin
                    if (mac[WIDTH+3:WIDTH] == 4'h0) acc_nxt = mac[WIDTH-1:0];
                    else ov_nxt = 1'b1;
                end else begin
                    case (key_code)
                        4'hA: begin
                            acc_nxt = acc / WIDTH'(10);
                            ov_nxt  = 1'b0;
                        end
                        4'hB, 4'hE: begin
                            acc_nxt = '0;
                            ov_nxt  = 1'b0;
                        end
                        4'hF: begin
                            out_nxt   = acc;
                            valid_nxt = 1'b1;
                            state_nxt = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            // Key events here are swallowed (armed still clears), even one coinciding with the handshake
            DONE: if (out_ready) begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b1;
            rel_cnt   <= '0;
            acc       <= '0;
            ov        <= 1'b0;
            out_valid <= 1'b0;
            out_value <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            ov        <= ov_nxt;
            out_valid <= valid_nxt;
            out_value <= out_nxt;
            rel_cnt   <= key_press ? '0 : (rel_cnt == REL_MAX ? rel_cnt : rel_cnt + 1'b1);
            // Re-arm only after a full quiet interval so scan gaps inside one press are bridged
            if (ev) armed <= 1'b0;
            else if (rel_cnt == REL_MAX) armed <= 1'b1;
        end
    end

    assign acc_value = acc;
    assign overflow  = ov;
    assign entering  = (state == ENTRY);
endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;
    localparam int W  = 16;
    localparam int RC = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   key_code = 4'h0;
    logic         key_press = 1'b0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_value;
    logic [W-1:0] acc_value;
    logic         entering;
    logic         overflow;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: 0 idle, 1 entry, 2 done
    int m_state, m_acc, m_out, m_quiet;
    bit m_ov, m_valid, m_armed;

    keypad_entry #(.WIDTH(W), .RELEASE_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_press(key_press),
        .out_ready(out_ready), .out_valid(out_valid), .out_value(out_value),
        .acc_value(acc_value), .entering(entering), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_acc = 0; m_out = 0; m_quiet = 0;
        m_ov = 0; m_valid = 0; m_armed = 1;
    endtask

    task automatic step();
        bit ev;
        @(posedge clk);
        ev = key_press && m_armed;
        if (m_state == 2) begin
            if (out_ready) begin m_valid = 0; m_state = 0; end
        end else if (ev) begin
            if (m_state == 0) begin
                if (key_code == 4'hE) begin m_state = 1; m_acc = 0; m_ov = 0; end
            end else if (key_code <= 4'h9) begin
                if (m_acc * 10 + int'(key_code) <= MAXV) m_acc = m_acc * 10 + int'(key_code);
                else m_ov = 1;
            end else if (key_code == 4'hA) begin
                m_acc = m_acc / 10; m_ov = 0;
            end else if (key_code == 4'hB || key_code == 4'hE) begin
                m_acc = 0; m_ov = 0;
            end else if (key_code == 4'hF) begin
                m_out = m_acc; m_valid = 1; m_state = 2;
            end
        end
        // a press is accepted once RC consecutive low cycles have elapsed, one cycle later
        if (ev) m_armed = 0;
        else if (m_quiet >= RC) m_armed = 1;
        m_quiet = key_press ? 0 : m_quiet + 1;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c; key_press = 1'b1;
        repeat (3) step();
        key_press = 1'b0; key_code = 4'($urandom);
        repeat (6) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; key_press = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        if (out_value !== '0) begin n_fail++; $display("FAIL reset_out_value: got %0d want 0", out_value); end
        if (acc_value !== '0) begin n_fail++; $display("FAIL reset_acc: got %0d want 0", acc_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL reset_entering: got %0b want 0", entering); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_basic_entry();
        press(4'hE);
        n_cmp++;
        if (entering !== 1'b1) begin n_fail++; $display("FAIL basic_entering: got %0b want 1", entering); end
        press(4'h1); press(4'h2); press(4'h3); press(4'hF);
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
        if (out_value !== 16'd123) begin n_fail++; $display("FAIL basic_value: got %0d want 123", out_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL basic_done_entering: got %0b want 0", entering); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drop: got %0b want 0", out_valid); end
        if (acc_value !== 16'd123) begin n_fail++; $display("FAIL basic_acc_hold: got %0d want 123", acc_value); end
        press(4'h5);
        n_cmp += 2;
        if (acc_value !== 16'd123) begin n_fail++; $display("FAIL basic_idle_ignore: got %0d want 123", acc_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL basic_idle_state: got %0b want 0", entering); end
    endtask

    task automatic test_debounce();
        press(4'hE);
        key_code = 4'h5; key_press = 1'b1; repeat (2) step();
        key_press = 1'b0; repeat (2) step();
        key_press = 1'b1; repeat (2) step();
        key_press = 1'b0; repeat (6) step();
        n_cmp++;
        if (acc_value !== 16'd5) begin n_fail++; $display("FAIL debounce_gap: got %0d want 5", acc_value); end
        press(4'h5);
        n_cmp++;
        if (acc_value !== 16'd55) begin n_fail++; $display("FAIL debounce_second: got %0d want 55", acc_value); end
    endtask

    task automatic test_editing();
        logic [3:0] keys [8] = '{4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'h7, 4'hA, 4'h9};
        int exp [8] = '{4, 45, 456, 45, 0, 7, 0, 9};
        press(4'hE);
        for (int i = 0; i < 8; i++) begin
            press(keys[i]);
            n_cmp++;
            if (int'(acc_value) != exp[i]) begin
                n_fail++; $display("FAIL edit_step%0d: got %0d want %0d", i, acc_value, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        press(4'hE);
        press(4'h6); press(4'h5); press(4'h5); press(4'h3); press(4'h5);
        n_cmp += 2;
        if (acc_value !== 16'd65535) begin n_fail++; $display("FAIL ovf_max: got %0d want 65535", acc_value); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_max_flag: got %0b want 0", overflow); end
        press(4'h6);
        n_cmp += 2;
        if (acc_value !== 16'd65535) begin n_fail++; $display("FAIL ovf_reject: got %0d want 65535", acc_value); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        press(4'hA);
        n_cmp += 2;
        if (acc_value !== 16'd6553) begin n_fail++; $display("FAIL ovf_back: got %0d want 6553", acc_value); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_ignore();
        do_reset();
        press(4'h3); press(4'hF);
        n_cmp += 3;
        if (acc_value !== '0) begin n_fail++; $display("FAIL ign_idle_acc: got %0d want 0", acc_value); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_idle_valid: got %0b want 0", out_valid); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL ign_idle_entering: got %0b want 0", entering); end
        press(4'hE); press(4'h7); press(4'hF);
        press(4'hE);
        n_cmp += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_done_valid: got %0b want 1", out_valid); end
        if (out_value !== 16'd7) begin n_fail++; $display("FAIL ign_done_value: got %0d want 7", out_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL ign_done_entering: got %0b want 0", entering); end
        key_code = 4'hE; key_press = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ign_simul_valid: got %0b want 0", out_valid); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL ign_simul_entering: got %0b want 0", entering); end
        repeat (2) step();
        key_press = 1'b0; repeat (6) step();
        n_cmp += 2;
        if (entering !== 1'b0) begin n_fail++; $display("FAIL ign_simul_after: got %0b want 0", entering); end
        if (acc_value !== 16'd7) begin n_fail++; $display("FAIL ign_simul_acc: got %0d want 7", acc_value); end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(4'hE); press(4'h1); press(4'h2);
        n_cmp++;
        if (acc_value !== 16'd12) begin n_fail++; $display("FAIL arst_pre: got %0d want 12", acc_value); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp += 4;
        if (acc_value !== '0) begin n_fail++; $display("FAIL arst_acc: got %0d want 0", acc_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL arst_entering: got %0b want 0", entering); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow: got %0b want 0", overflow); end
        @(negedge clk); rst_n = 1'b1;
        press(4'h1);
        n_cmp += 2;
        if (acc_value !== '0) begin n_fail++; $display("FAIL arst_after_acc: got %0d want 0", acc_value); end
        if (entering !== 1'b0) begin n_fail++; $display("FAIL arst_after_entering: got %0b want 0", entering); end
    endtask

    task automatic test_random();
        int hi, lo;
        logic [3:0] c;
        do_reset();
        for (int p = 0; p < 200; p++) begin
            c = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 4'hE : 4'hF) : 4'($urandom_range(0, 15));
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 7);
            for (int i = 0; i < hi + lo; i++) begin
                key_press = (i < hi);
                key_code = (i < hi) ? c : 4'($urandom);
                out_ready = ($urandom_range(0, 3) == 0);
                step();
                n_cmp++;
                if (out_valid !== m_valid || int'(out_value) != m_out || int'(acc_value) != m_acc
                    || entering !== (m_state == 1) || overflow !== m_ov) begin
                    n_fail++;
                    $display("FAIL random p%0d c%0d: got v=%0b o=%0d a=%0d e=%0b ov=%0b want v=%0b o=%0d a=%0d e=%0b ov=%0b",
                             p, i, out_valid, out_value, acc_value, entering, overflow,
                             m_valid, m_out, m_acc, m_state == 1, m_ov);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_entry();
        test_debounce();
        test_editing();
        test_overflow();
        test_ignore();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
